// File: rtl/snoop_command_controller.sv
// Bus debugger command sequencer: decodes single-byte host commands, drives the
// snooper record/dump controls and arbitrates the shared TX byte stream.
module snoop_command_controller #(
  parameter int unsigned              TIMEOUT_WIDTH = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] DUMP_TIMEOUT  = 24'd16000000
) (
  input  logic       comm_clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_available,
  input  logic       rx_error,
  output logic       rx_acknowledge,
  output logic       record_start,
  output logic       record_trigger,
  input  logic       record_end,
  output logic       dump_start,
  input  logic       dump_end,
  input  logic [7:0] snoop_data,
  input  logic       snoop_valid,
  output logic       snoop_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam logic [7:0] CMD_RECORD  = 8'h72;
  localparam logic [7:0] CMD_TRIGGER = 8'h74;
  localparam logic [7:0] CMD_STATUS  = 8'h73;
  localparam logic [7:0] CMD_CLEAR   = 8'h63;
  localparam logic [7:0] CMD_DUMP    = 8'h64;

  localparam logic [7:0] RESP_OK      = 8'h6B;
  localparam logic [7:0] RESP_UNKNOWN = 8'h3F;
  localparam logic [7:0] DUMP_HEADER  = 8'h44;
  localparam logic [7:0] TRL_DONE     = 8'h2E;
  localparam logic [7:0] TRL_TIMEOUT  = 8'h21;

  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = DUMP_TIMEOUT - TIMEOUT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RESP,
    S_DUMP_HDR,
    S_DUMP_STREAM,
    S_DUMP_TRL
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [7:0]               resp_q, resp_d;
  logic                     armed_q, armed_d;
  logic                     captured_q, captured_d;
  logic                     rx_err_q, rx_err_d;
  logic                     timeout_q, timeout_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     ack_d, rec_start_d, rec_trig_d, dump_start_d;

  // State, latched command/response, flags, watchdog and registered pulses
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cmd_q          <= 8'h00;
      resp_q         <= 8'h00;
      armed_q        <= 1'b0;
      captured_q     <= 1'b0;
      rx_err_q       <= 1'b0;
      timeout_q      <= 1'b0;
      wd_q           <= '0;
      rx_acknowledge <= 1'b0;
      record_start   <= 1'b0;
      record_trigger <= 1'b0;
      dump_start     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      resp_q         <= resp_d;
      armed_q        <= armed_d;
      captured_q     <= captured_d;
      rx_err_q       <= rx_err_d;
      timeout_q      <= timeout_d;
      wd_q           <= wd_d;
      rx_acknowledge <= ack_d;
      record_start   <= rec_start_d;
      record_trigger <= rec_trig_d;
      dump_start     <= dump_start_d;
      busy           <= (state_d != S_IDLE);
    end
  end

  // Next-state, flag and pulse logic
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    resp_d       = resp_q;
    armed_d      = armed_q;
    captured_d   = captured_q;
    rx_err_d     = rx_err_q;
    timeout_d    = timeout_q;
    wd_d         = wd_q;
    ack_d        = 1'b0;
    rec_start_d  = 1'b0;
    rec_trig_d   = 1'b0;
    dump_start_d = 1'b0;

    // Asynchronous events first so that command decode below can override them
    if (record_end) begin
      captured_d = 1'b1;
      armed_d    = 1'b0;
    end
    if (rx_error) begin
      rx_err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_available) begin
          cmd_d   = rx_data;
          ack_d   = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_RESP;
        unique case (cmd_q)
          CMD_RECORD: begin
            rec_start_d = 1'b1;
            armed_d     = 1'b1;
            captured_d  = 1'b0;
            resp_d      = RESP_OK;
          end
          CMD_TRIGGER: begin
            rec_trig_d = 1'b1;
            resp_d     = RESP_OK;
          end
          CMD_STATUS: begin
            resp_d = {4'hA, timeout_q, rx_err_q, captured_q, armed_q};
          end
          CMD_CLEAR: begin
            // A framing error arriving in the same cycle is still recorded
            rx_err_d  = rx_error;
            timeout_d = 1'b0;
            resp_d    = RESP_OK;
          end
          CMD_DUMP: begin
            resp_d  = DUMP_HEADER;
            state_d = S_DUMP_HDR;
          end
          default: begin
            resp_d = RESP_UNKNOWN;
          end
        endcase
      end

      S_RESP: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DUMP_HDR: begin
        if (tx_ready) begin
          dump_start_d = 1'b1;
          wd_d         = '0;
          state_d      = S_DUMP_STREAM;
        end
      end

      S_DUMP_STREAM: begin
        if (dump_end) begin
          resp_d  = TRL_DONE;
          state_d = S_DUMP_TRL;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          resp_d    = TRL_TIMEOUT;
          state_d   = S_DUMP_TRL;
        end else begin
          wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
      end

      S_DUMP_TRL: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // TX arbitration: own bytes from resp_q, snooper stream passed straight through
  always_comb begin
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    snoop_ready = 1'b0;
    unique case (state_q)
      S_RESP, S_DUMP_HDR, S_DUMP_TRL: begin
        tx_data  = resp_q;
        tx_valid = 1'b1;
      end
      S_DUMP_STREAM: begin
        tx_data     = snoop_data;
        tx_valid    = snoop_valid;
        snoop_ready = tx_ready;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_snoop_command_controller.sv
// Directed bench for snoop_command_controller with small receiver, snooper and
// transmitter models driven once per cycle on the falling edge.
module tb_snoop_command_controller;

  logic       comm_clock;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_error;
  logic       rx_acknowledge;
  logic       record_start;
  logic       record_trigger;
  logic       record_end;
  logic       dump_start;
  logic       dump_end;
  logic [7:0] snoop_data;
  logic       snoop_valid;
  logic       snoop_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  snoop_command_controller #(
    .TIMEOUT_WIDTH(24),
    .DUMP_TIMEOUT (24'd100)
  ) dut (
    .comm_clock    (comm_clock),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_available  (rx_available),
    .rx_error      (rx_error),
    .rx_acknowledge(rx_acknowledge),
    .record_start  (record_start),
    .record_trigger(record_trigger),
    .record_end    (record_end),
    .dump_start    (dump_start),
    .dump_end      (dump_end),
    .snoop_data    (snoop_data),
    .snoop_valid   (snoop_valid),
    .snoop_ready   (snoop_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  initial comm_clock = 1'b0;
  always #5 comm_clock = ~comm_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [7:0] tx_log[$];
  logic [7:0] snoop_bytes[8];
  int         snoop_n, snoop_idx;
  bit         snoop_active, snoop_done, snoop_end_en;
  bit         rx_pending;
  logic [7:0] rx_byte;
  bit         pend_rx_error, pend_record_end;
  int         ack_cnt, rs_cnt, rt_cnt, ds_cnt, sr_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  // One clock cycle: drive all models at the falling edge, observe just after
  task automatic tick(input bit rdy);
    @(negedge comm_clock);
    tx_ready        = rdy;
    rx_available    = rx_pending;
    rx_data         = rx_byte;
    rx_error        = pend_rx_error;
    pend_rx_error   = 1'b0;
    record_end      = pend_record_end;
    pend_record_end = 1'b0;
    dump_end        = 1'b0;
    if (snoop_active && snoop_end_en && snoop_idx == snoop_n && !snoop_done) begin
      dump_end   = 1'b1;
      snoop_done = 1'b1;
    end
    snoop_valid = snoop_active && (snoop_idx < snoop_n);
    snoop_data  = snoop_valid ? snoop_bytes[snoop_idx] : 8'h00;
    #1;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (snoop_valid && snoop_ready) snoop_idx++;
    if (rx_acknowledge) begin
      ack_cnt++;
      rx_pending = 1'b0;
    end
    if (record_start) rs_cnt++;
    if (record_trigger) rt_cnt++;
    if (dump_start) begin
      ds_cnt++;
      snoop_active = 1'b1;
    end
    if (snoop_ready) sr_cnt++;
  endtask

  task automatic snoop_setup(input int n, input bit end_en);
    snoop_n      = n;
    snoop_end_en = end_en;
    snoop_idx    = 0;
    snoop_active = 1'b0;
    snoop_done   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge comm_clock);
    reset_n = 1'b0;
    rx_pending = 1'b0;
    snoop_setup(0, 1'b0);
    repeat (2) @(negedge comm_clock);
    reset_n = 1'b1;
  endtask

  // Send one command byte with tx_ready high and return the first TX byte
  task automatic run_cmd(input logic [7:0] b, input bit end_in_exec, output logic [7:0] resp);
    rx_byte    = b;
    rx_pending = 1'b1;
    tx_log.delete();
    for (int k = 1; k <= 60 && tx_log.size() == 0; k++) begin
      if (k == 2 && end_in_exec) pend_record_end = 1'b1;
      tick(1'b1);
    end
    check("cmd_wait", tx_log.size(), 1);
    resp = log_at(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] r;
    int base, base2;
    reset_n = 1'b1;
    rx_data = 8'h00; rx_available = 1'b0; rx_error = 1'b0; record_end = 1'b0;
    dump_end = 1'b0; snoop_data = 8'h00; snoop_valid = 1'b0; tx_ready = 1'b0;
    rx_pending = 1'b0; rx_byte = 8'h00; pend_rx_error = 1'b0; pend_record_end = 1'b0;
    ack_cnt = 0; rs_cnt = 0; rt_cnt = 0; ds_cnt = 0; sr_cnt = 0;
    snoop_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    snoop_setup(0, 1'b0);
    #2 reset_n = 1'b0;

    // Reset values
    @(negedge comm_clock); #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", rx_acknowledge, 0);
    check("rst_dump_start", dump_start, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge comm_clock);
    reset_n = 1'b1;

    // Status after reset, single acknowledge pulse, idle after transfer
    base = ack_cnt;
    run_cmd(8'h73, 1'b0, r);
    check("s_reset", r, 8'hA0);
    check("s_ack_once", ack_cnt - base, 1);
    tick(1'b0);
    check("s_busy_low", busy, 0);

    // Record arm, capture, and arm winning over a coincident record_end
    base = rs_cnt;
    run_cmd(8'h72, 1'b0, r);
    check("r_resp", r, 8'h6B);
    check("r_pulse", rs_cnt - base, 1);
    run_cmd(8'h73, 1'b0, r);
    check("s_armed", r, 8'hA1);
    pend_record_end = 1'b1;
    tick(1'b0);
    run_cmd(8'h73, 1'b0, r);
    check("s_captured", r, 8'hA2);
    run_cmd(8'h72, 1'b1, r);
    check("r2_resp", r, 8'h6B);
    run_cmd(8'h73, 1'b0, r);
    check("s_arm_wins", r, 8'hA1);
    base = rt_cnt;
    run_cmd(8'h74, 1'b0, r);
    check("t_resp", r, 8'h6B);
    check("t_pulse", rt_cnt - base, 1);

    // Dump of three bytes with tx_ready toggling
    apply_reset();
    snoop_setup(3, 1'b1);
    base = ds_cnt;
    rx_byte = 8'h64; rx_pending = 1'b1; tx_log.delete();
    for (int k = 0; k < 200 && tx_log.size() < 5; k++) tick(k[0] == 1'b0);
    repeat (4) tick(1'b1);
    check("dump_len", tx_log.size(), 5);
    check("dump_b0", log_at(0), 8'h44);
    check("dump_b1", log_at(1), 8'h11);
    check("dump_b2", log_at(2), 8'h22);
    check("dump_b3", log_at(3), 8'h33);
    check("dump_b4", log_at(4), 8'h2E);
    check("dump_start_once", ds_cnt - base, 1);

    // Watchdog expiry with a silent snooper
    snoop_setup(0, 1'b0);
    base = sr_cnt;
    rx_byte = 8'h64; rx_pending = 1'b1; tx_log.delete();
    for (int k = 0; k < 300 && tx_log.size() < 2; k++) tick(1'b1);
    check("to_len", tx_log.size(), 2);
    check("to_hdr", log_at(0), 8'h44);
    check("to_trl", log_at(1), 8'h21);
    check("to_cycles", sr_cnt - base, 100);
    snoop_setup(0, 1'b0);
    run_cmd(8'h73, 1'b0, r);
    check("s_timeout", r, 8'hA8);
    run_cmd(8'h63, 1'b0, r);
    check("c_resp", r, 8'h6B);
    run_cmd(8'h73, 1'b0, r);
    check("s_cleared", r, 8'hA0);

    // Framing error flag, unknown command, byte held off while responding
    pend_rx_error = 1'b1;
    tick(1'b1);
    run_cmd(8'h73, 1'b0, r);
    check("s_rx_err", r, 8'hA4);
    base = ack_cnt;
    rx_byte = 8'h55; rx_pending = 1'b1; tx_log.delete();
    repeat (3) tick(1'b0);
    rx_byte = 8'h73; rx_pending = 1'b1;
    repeat (4) tick(1'b0);
    check("hold_no_ack", ack_cnt - base, 1);
    check("hold_busy", busy, 1);
    for (int k = 0; k < 60 && tx_log.size() < 2; k++) tick(1'b1);
    check("unk_resp", log_at(0), 8'h3F);
    check("held_resp", log_at(1), 8'hA4);
    check("held_ack", ack_cnt - base, 2);

    // Reset in the middle of a dump stream
    snoop_setup(8, 1'b0);
    rx_byte = 8'h64; rx_pending = 1'b1; tx_log.delete();
    for (int k = 0; k < 60 && snoop_idx < 2; k++) tick(1'b1);
    check("mid_stream", tx_log.size(), 3);
    @(negedge comm_clock);
    reset_n = 1'b0;
    snoop_valid = 1'b1; snoop_data = 8'h5A; tx_ready = 1'b1;
    #1;
    check("mr_tx_valid", tx_valid, 0);
    check("mr_tx_data", tx_data, 0);
    check("mr_snoop_ready", snoop_ready, 0);
    check("mr_busy", busy, 0);
    snoop_setup(0, 1'b0);
    rx_pending = 1'b0;
    @(negedge comm_clock);
    reset_n = 1'b1;
    tx_log.delete();
    repeat (10) tick(1'b1);
    check("mr_no_trailer", tx_log.size(), 0);
    run_cmd(8'h73, 1'b0, r);
    check("mr_status", r, 8'hA0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
